cmd_uart_wrapper: RTL and testbench
===================================

Name: cmd_uart_wrapper

Overview:
Knight-side end of the remote command link. It receives 8N1 UART bytes from the remote controller, assembles two consecutive bytes (high byte first) into a 16-bit command, and presents it to the command processor with a ready flag. It also serializes one 8-bit response byte back to the remote, e.g. 0xA5 positive acknowledge, and reports completion. It sits between the RX/TX pins and cmd_proc inside KnightsTour.

Parameters:
BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); 12-bit counter width.
TIMEOUT_CLKS, 2500000, inter-byte timeout in clocks; used only with CMD_TIMEOUT_EN.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
RX  in  1  serial input from remote; asynchronous to clk
TX  out  1  serial output to remote; idles high
clr_cmd_rdy  in  1  consumer pulse; clears cmd_rdy
cmd_rdy  out  1  full 16-bit command valid
cmd  out  16  assembled command, {first byte, second byte}
trmt  in  1  pulse; start transmitting resp
resp  in  8  response byte; sampled on the trmt cycle
tx_done  out  1  response frame fully sent

Behaviour:
- Reset values: cmd=16'h0000, cmd_rdy=0, TX=1, tx_done=0. Assembler FSM goes to HIGH. The RX and TX engines go idle.
- Reset is asynchronous to all flops. Reset mid-frame aborts both engines. Any partial byte or latched high byte is discarded.
- RX engine:
  - RX passes through a 2-flop synchronizer, preset high on reset.
  - A start bit is a falling edge while idle. The baud counter loads BAUD_DIV/2 for the first sample, then BAUD_DIV.
  - It samples 10 bits, LSB first. It pulses rx_rdy for 1 clk with rx_data on stop-bit sample.
  - Stop bit = 0 is a framing error: the byte is dropped, no rx_rdy.
- Assembler FSM, 2 states:
  - HIGH: on rx_rdy, cmd[15:8] <= rx_data, cmd_rdy <= 0, go LOW.
  - LOW: on rx_rdy, cmd[7:0] <= rx_data, cmd_rdy <= 1 on the same edge, go HIGH.
  - Latency: cmd_rdy rises 1 clk after the second byte's stop-bit sample.
  - cmd[15:0] is stable while cmd_rdy=1, except when a new high byte arrives; that byte updates cmd[15:8] and clears cmd_rdy in the same edge.
  - A set event and clr_cmd_rdy in the same cycle: set wins.
  - clr_cmd_rdy with cmd_rdy=0 has no effect.
- TX engine:
  - On trmt while idle: latch {1'b1, resp, 1'b0} into a 10-bit shift register, clear tx_done, drive the start bit next clk.
  - Each bit is held exactly BAUD_DIV clks.
  - After the stop bit's BAUD_DIV clks: go idle, set tx_done. tx_done stays set until the next accepted trmt.
  - trmt while busy is ignored; the current frame is unchanged.
- RX and TX are fully independent; full-duplex operation is allowed.

Optional Feature:
Macro CMD_UART_TIMEOUT_EN.
- Defined: a counter runs in LOW and resets on each entry to LOW. When it reaches TIMEOUT_CLKS-1 without a second byte, the FSM returns to HIGH. The latched high byte is abandoned and cmd_rdy stays 0. The next received byte is treated as a high byte.
- Undefined: LOW waits indefinitely. No counter logic is synthesized.

Decomposition:
- Shared package knight_pkg: typedef enum {HIGH, LOW} asm_state_t; constants POS_ACK=8'hA5, BAUD_DIV_50M=2604.
- One sub-module, uart_xcvr: RX engine, TX engine and synchronizer. Ports: clk, rst_n, RX, TX, rx_rdy, rx_data, trmt, tx_data, tx_done.
- cmd_uart_wrapper holds only the assembler FSM, the cmd register, cmd_rdy and the optional timeout.

Test Plan:
- Remote sends 16'h4BF1 → cmd_rdy rises once; cmd=16'h4BF1. Pulse clr_cmd_rdy → cmd_rdy=0 next clk, cmd unchanged.
- trmt with resp=8'hA5 → TX shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each BAUD_DIV clks. tx_done=1 after the stop bit. The remote decodes 0xA5.
- Back-to-back 16'h4BF1 then 16'h57F2, with no clr between → cmd_rdy drops on 0x57's arrival and rises with cmd=16'h57F2.
- Inject byte 0x4B with stop bit forced 0, then a valid 0x57 and 0xF2 → framing byte dropped; cmd=16'h57F2.
- Assert rst_n low mid-second-byte → cmd=0, cmd_rdy=0, TX=1. The next full command is received correctly.
- With CMD_UART_TIMEOUT_EN and TIMEOUT_CLKS=1000: send 0x4B, idle 1000 clks, then send 0x57, 0xF2 → cmd=16'h57F2, a single cmd_rdy.

Source files
------------

// File: rtl/knight_pkg.sv
// Shared types and constants for the Knight-side remote command link.
// Holds the assembler state encoding, the positive-ack byte and the default baud divisor.
package knight_pkg;

   typedef enum logic {
      HIGH = 1'b0,
      LOW  = 1'b1
   } asm_state_t;

   localparam logic [7:0]  POS_ACK      = 8'hA5;
   localparam int unsigned BAUD_DIV_50M = 2604;
   localparam int unsigned BAUD_CNT_W   = 12;

endpackage

// File: rtl/uart_xcvr.sv
// 8N1 UART transceiver: synchronized RX engine with framing check, and TX engine.
// RX and TX share nothing but clk/rst_n and may run simultaneously.
module uart_xcvr
   import knight_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_50M
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic       TX,
   output logic       rx_rdy,
   output logic [7:0] rx_data,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx_done
);

   localparam logic [BAUD_CNT_W-1:0] BAUD_FULL = BAUD_CNT_W'(BAUD_DIV);
   localparam logic [BAUD_CNT_W-1:0] BAUD_HALF = BAUD_CNT_W'(BAUD_DIV / 2);

   logic                  rx_meta_q, rx_sync_q, rx_prev_q;
   logic                  rx_busy_q, rx_busy_d;
   logic [BAUD_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [3:0]            rx_bit_q, rx_bit_d;
   logic [8:0]            rx_shift_q, rx_shift_d;

   logic                  tx_busy_q, tx_busy_d;
   logic [BAUD_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]            tx_bit_q, tx_bit_d;
   logic [9:0]            tx_shift_q, tx_shift_d;
   logic                  tx_done_q, tx_done_d;

   // NOTE: every variable gets its default before any branch so no latch can be inferred.
   always_comb begin
      rx_busy_d  = rx_busy_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_rdy     = 1'b0;
      if (!rx_busy_q) begin
         if (rx_prev_q && !rx_sync_q) begin
            rx_busy_d = 1'b1;
            rx_cnt_d  = BAUD_HALF;
            rx_bit_d  = 4'd0;
         end
      end else if (rx_cnt_q == BAUD_CNT_W'(1)) begin
         rx_cnt_d = BAUD_FULL;
         if (rx_bit_q == 4'd9) begin
            // A low stop bit is a framing error: drop the byte silently.
            rx_busy_d = 1'b0;
            rx_rdy    = rx_sync_q;
         end else begin
            rx_shift_d = {rx_sync_q, rx_shift_q[8:1]};
            rx_bit_d   = rx_bit_q + 4'd1;
         end
      end else begin
         rx_cnt_d = rx_cnt_q - BAUD_CNT_W'(1);
      end
   end

   assign rx_data = rx_shift_q[8:1];

   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_done_d  = tx_done_q;
      if (!tx_busy_q) begin
         if (trmt) begin
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, tx_data, 1'b0};
            tx_cnt_d   = BAUD_FULL - BAUD_CNT_W'(1);
            tx_bit_d   = 4'd0;
            tx_done_d  = 1'b0;
         end
      end else if (tx_cnt_q == '0) begin
         tx_shift_d = {1'b1, tx_shift_q[9:1]};
         tx_cnt_d   = BAUD_FULL - BAUD_CNT_W'(1);
         if (tx_bit_q == 4'd9) begin
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
         end else begin
            tx_bit_d = tx_bit_q + 4'd1;
         end
      end else begin
         tx_cnt_d = tx_cnt_q - BAUD_CNT_W'(1);
      end
   end

   assign TX      = tx_shift_q[0];
   assign tx_done = tx_done_q;

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the synchronizer and TX shifter reset to the idle-line level (1), not 0.
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_busy_q  <= 1'b0;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         tx_busy_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '1;
         tx_done_q  <= 1'b0;
      end else begin
         rx_meta_q  <= RX;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_busy_q  <= rx_busy_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         tx_busy_q  <= tx_busy_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_done_q  <= tx_done_d;
      end
   end

endmodule

// File: rtl/cmd_uart_wrapper.sv
// Assembles two UART bytes (high first) into a 16-bit command and sends one response byte.
// Define CMD_UART_TIMEOUT_EN to abandon a lone high byte after TIMEOUT_CLKS idle clocks.
module cmd_uart_wrapper
   import knight_pkg::*;
#(
   parameter int unsigned BAUD_DIV     = BAUD_DIV_50M,
   parameter int unsigned TIMEOUT_CLKS = 2500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   input  logic        clr_cmd_rdy,
   output logic        cmd_rdy,
   output logic [15:0] cmd,
   input  logic        trmt,
   input  logic [7:0]  resp,
   output logic        tx_done
);

   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        tmo_hit;

   asm_state_t  state_q, state_d;
   logic [15:0] cmd_q, cmd_d;
   logic        cmd_rdy_q, cmd_rdy_d;

   uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
      .clk    (clk),
      .rst_n  (rst_n),
      .RX     (RX),
      .TX     (TX),
      .rx_rdy (rx_rdy),
      .rx_data(rx_data),
      .trmt   (trmt),
      .tx_data(resp),
      .tx_done(tx_done)
   );

`ifdef CMD_UART_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS);

   logic [TMO_W-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d   = (state_q == LOW) ? tmo_q + TMO_W'(1) : '0;
      tmo_hit = (state_q == LOW) && (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // A set in the same cycle as clr_cmd_rdy wins because it is assigned last.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      cmd_rdy_d = cmd_rdy_q;
      if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
      case (state_q)
         HIGH: if (rx_rdy) begin
            cmd_d[15:8] = rx_data;
            cmd_rdy_d   = 1'b0;
            state_d     = LOW;
         end
         LOW: if (rx_rdy) begin
            cmd_d[7:0] = rx_data;
            cmd_rdy_d  = 1'b1;
            state_d    = HIGH;
         end else if (tmo_hit) begin
            state_d = HIGH;
         end
         default: state_d = HIGH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HIGH;
         cmd_q     <= '0;
         cmd_rdy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         cmd_rdy_q <= cmd_rdy_d;
      end
   end

   assign cmd     = cmd_q;
   assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Directed bench for cmd_uart_wrapper with a shortened baud divisor.
// The timeout scenario runs only when CMD_UART_TIMEOUT_EN is defined.
module tb_cmd_uart_wrapper;

   localparam int BD  = 16;
   localparam int TMO = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RX = 1'b1;
   logic        clr_cmd_rdy = 1'b0;
   logic        trmt = 1'b0;
   logic [7:0]  resp = 8'h00;
   logic        TX;
   logic        cmd_rdy;
   logic [15:0] cmd;
   logic        tx_done;

   int   tests = 0;
   int   fails = 0;
   int   rises = 0;
   logic rdy_prev = 1'b0;

   cmd_uart_wrapper #(.BAUD_DIV(BD), .TIMEOUT_CLKS(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .TX         (TX),
      .clr_cmd_rdy(clr_cmd_rdy),
      .cmd_rdy    (cmd_rdy),
      .cmd        (cmd),
      .trmt       (trmt),
      .resp       (resp),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cmd_rdy && !rdy_prev) rises++;
      rdy_prev = cmd_rdy;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] data, input logic stop, input int nbits);
      logic [9:0] frame;
      frame = {stop, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         RX = frame[i];
         wait_clks(BD);
      end
   endtask

   task automatic send_byte(input logic [7:0] data);
      send_bits(data, 1'b1, 10);
      RX = 1'b1;
      wait_clks(BD);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      wait_clks(3);
      tests++; if (cmd !== 16'h0000) begin fails++; $display("FAIL reset_cmd: got %h expected 0000", cmd); end
      tests++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
      tests++; if (TX !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", TX); end
      tests++; if (tx_done !== 1'b0) begin fails++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
      rst_n = 1'b1;
      wait_clks(2);
   endtask

   task automatic test_single_cmd;
      int r0;
      r0 = rises;
      send_byte(8'h4B);
      tests++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL single_first_rdy: got %b expected 0", cmd_rdy); end
      tests++; if (cmd[15:8] !== 8'h4B) begin fails++; $display("FAIL single_high: got %h expected 4b", cmd[15:8]); end
      send_byte(8'hF1);
      tests++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL single_rdy: got %b expected 1", cmd_rdy); end
      tests++; if (cmd !== 16'h4BF1) begin fails++; $display("FAIL single_cmd: got %h expected 4bf1", cmd); end
      tests++; if (rises - r0 !== 1) begin fails++; $display("FAIL single_rises: got %0d expected 1", rises - r0); end
      clr_cmd_rdy = 1'b1;
      wait_clks(1);
      clr_cmd_rdy = 1'b0;
      tests++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL clr_rdy: got %b expected 0", cmd_rdy); end
      tests++; if (cmd !== 16'h4BF1) begin fails++; $display("FAIL clr_cmd_kept: got %h expected 4bf1", cmd); end
      clr_cmd_rdy = 1'b1;
      wait_clks(1);
      clr_cmd_rdy = 1'b0;
      tests++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL clr_idle_rdy: got %b expected 0", cmd_rdy); end
   endtask

   task automatic test_tx;
      logic [9:0] exp_frame;
      logic [7:0] decoded;
      exp_frame = {1'b1, 8'hA5, 1'b0};
      decoded   = 8'h00;
      resp = 8'hA5;
      trmt = 1'b1;
      wait_clks(1);
      trmt = 1'b0;
      wait_clks(BD / 2 - 1);
      for (int j = 0; j < 10; j++) begin
         tests++;
         if (TX !== exp_frame[j]) begin
            fails++; $display("FAIL tx_bit%0d: got %b expected %b", j, TX, exp_frame[j]);
         end
         if (j >= 1 && j <= 8) decoded[j-1] = TX;
         if (j == 0) begin
            tests++; if (tx_done !== 1'b0) begin fails++; $display("FAIL tx_done_busy: got %b expected 0", tx_done); end
         end
         if (j == 2) begin
            resp = 8'h00;
            trmt = 1'b1;
            wait_clks(1);
            trmt = 1'b0;
            wait_clks(BD - 1);
         end else if (j < 9) begin
            wait_clks(BD);
         end
      end
      tests++; if (decoded !== 8'hA5) begin fails++; $display("FAIL tx_decode: got %h expected a5", decoded); end
      wait_clks(BD / 2);
      tests++; if (tx_done !== 1'b0) begin fails++; $display("FAIL tx_done_early: got %b expected 0", tx_done); end
      wait_clks(1);
      tests++; if (tx_done !== 1'b1) begin fails++; $display("FAIL tx_done_set: got %b expected 1", tx_done); end
      tests++; if (TX !== 1'b1) begin fails++; $display("FAIL tx_idle: got %b expected 1", TX); end
      wait_clks(5);
      tests++; if (tx_done !== 1'b1) begin fails++; $display("FAIL tx_done_hold: got %b expected 1", tx_done); end
   endtask

   task automatic test_framing;
      int r0;
      r0 = rises;
      send_bits(8'h4B, 1'b0, 10);
      RX = 1'b1;
      wait_clks(BD);
      tests++; if (cmd !== 16'h4BF1) begin fails++; $display("FAIL frame_dropped: got %h expected 4bf1", cmd); end
      send_byte(8'h57);
      send_byte(8'hF2);
      tests++; if (cmd !== 16'h57F2) begin fails++; $display("FAIL frame_cmd: got %h expected 57f2", cmd); end
      tests++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL frame_rdy: got %b expected 1", cmd_rdy); end
      tests++; if (rises - r0 !== 1) begin fails++; $display("FAIL frame_rises: got %0d expected 1", rises - r0); end
   endtask

   task automatic test_back_to_back;
      int r0;
      r0 = rises;
      send_byte(8'h4B);
      tests++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL b2b_drop1: got %b expected 0", cmd_rdy); end
      send_byte(8'hF1);
      tests++; if (cmd !== 16'h4BF1) begin fails++; $display("FAIL b2b_cmd1: got %h expected 4bf1", cmd); end
      send_byte(8'h57);
      tests++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL b2b_drop2: got %b expected 0", cmd_rdy); end
      tests++; if (cmd !== 16'h57F1) begin fails++; $display("FAIL b2b_partial: got %h expected 57f1", cmd); end
      send_byte(8'hF2);
      tests++; if (cmd !== 16'h57F2) begin fails++; $display("FAIL b2b_cmd2: got %h expected 57f2", cmd); end
      tests++; if (rises - r0 !== 2) begin fails++; $display("FAIL b2b_rises: got %0d expected 2", rises - r0); end
   endtask

   task automatic test_reset_mid;
      send_byte(8'h4B);
      send_bits(8'h57, 1'b1, 5);
      #3 rst_n = 1'b0;
      #1;
      tests++; if (cmd !== 16'h0000) begin fails++; $display("FAIL midrst_cmd: got %h expected 0000", cmd); end
      tests++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL midrst_rdy: got %b expected 0", cmd_rdy); end
      tests++; if (TX !== 1'b1) begin fails++; $display("FAIL midrst_tx: got %b expected 1", TX); end
      tests++; if (tx_done !== 1'b0) begin fails++; $display("FAIL midrst_tx_done: got %b expected 0", tx_done); end
      RX = 1'b1;
      wait_clks(2);
      rst_n = 1'b1;
      wait_clks(2);
      send_byte(8'h12);
      send_byte(8'h34);
      tests++; if (cmd !== 16'h1234) begin fails++; $display("FAIL midrst_next_cmd: got %h expected 1234", cmd); end
      tests++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL midrst_next_rdy: got %b expected 1", cmd_rdy); end
   endtask

`ifdef CMD_UART_TIMEOUT_EN
   task automatic test_timeout;
      int r0;
      clr_cmd_rdy = 1'b1;
      wait_clks(1);
      clr_cmd_rdy = 1'b0;
      r0 = rises;
      send_byte(8'h4B);
      wait_clks(TMO);
      tests++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL tmo_idle_rdy: got %b expected 0", cmd_rdy); end
      send_byte(8'h57);
      send_byte(8'hF2);
      tests++; if (cmd !== 16'h57F2) begin fails++; $display("FAIL tmo_cmd: got %h expected 57f2", cmd); end
      tests++; if (rises - r0 !== 1) begin fails++; $display("FAIL tmo_rises: got %0d expected 1", rises - r0); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_cmd();
      test_tx();
      test_framing();
      test_back_to_back();
      test_reset_mid();
`ifdef CMD_UART_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
